data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter LATENCY, default 4: memory access cycles, legal range 1..15.
REQ-002 Parameter AW, default 8: word-index width; storage SHALL be 2^AW 16-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  16  byte address, driven from ALUOut_EM.
REQ-006 wdata  input  16  store data, driven from R2Data_EM.
REQ-007 rd_en  input  1  load request, driven from memReadEnable_EM.
REQ-008 wr_en  input  1  store request, driven from memWriteEnable_EM.
REQ-009 halt  input  1  halt marker, driven from halt_EM.
REQ-010 rdata  output  16  load result.
REQ-011 done  output  1  one-cycle pulse marking access completion.
REQ-012 stall  output  1  holds EX/MEM and the upstream stages while high.
REQ-013 err  output  1  illegal request flag.

Function
REQ-014 A request SHALL be rd_en|wr_en; a request is valid only when addr[0]==0 and exactly one of rd_en, wr_en is 1.
REQ-015 The word index SHALL be addr[AW:1]; higher address bits are ignored, so addresses alias modulo 2^(AW+1) bytes.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE and HALTED, with a 4-bit down-counter cnt.
REQ-017 IDLE with a valid request: latch index, wdata and op; load cnt=LATENCY-1; go to BUSY.
REQ-018 IDLE with an invalid request: err=1 combinationally in that cycle; no access; stall=0; stay in IDLE.
REQ-019 IDLE with halt=1 and no request: go to HALTED.
REQ-020 Request and halt in the same IDLE cycle: the request has priority and halt is not taken.
REQ-021 stall SHALL be 1 combinationally in IDLE whenever a valid request is present, and 1 throughout BUSY.
REQ-022 stall SHALL be 0 in DONE, in HALTED, and in IDLE with no valid request.
REQ-023 BUSY: on each edge, if cnt!=0, decrement cnt.
REQ-024 BUSY with cnt==0 at the edge:
- store: write the latched wdata to the array;
- load: register the array word into rdata;
- go to DONE.
REQ-025 BUSY SHALL last exactly LATENCY cycles.
REQ-026 Request inputs are ignored while in BUSY; only the latched copies are used.
REQ-027 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- No request is accepted in DONE, because EX/MEM still holds the completed request.
REQ-028 Total per access: stall high for LATENCY+1 consecutive cycles, then done high in the next cycle.
REQ-029 rdata SHALL hold its value until the next load completes; stores leave rdata unchanged.
REQ-030 A load issued after a store to the same index SHALL return the stored data.
REQ-031 HALTED: all requests ignored; stall=0, done=0, err=0; leave HALTED only on rst.
REQ-032 err SHALL be 0 in every state other than IDLE.

Reset
REQ-033 rst=1 SHALL immediately force: state=IDLE, cnt=0, rdata=0x0000, done=0, stall=0, err=0.
REQ-034 Reset during BUSY SHALL abort the access; a pending store is not written.
REQ-035 Array contents are not reset; benches SHALL write before reading.

Verification (LATENCY=4, AW=8)
REQ-036 Store then load:
- store 0x1234 to 0x0010: stall high 5 cycles, done pulse in cycle 6;
- then load from 0x0010: same timing, rdata=0x1234 in the done cycle.
REQ-037 Load from 0x0011: err=1 and stall=0 in the same cycle; no BUSY entry; done never asserts.
REQ-038 rd_en=wr_en=1 at 0x0020: err=1; the array at 0x0020 is unchanged (confirm with a later load).
REQ-039 Aliasing: store 0xBEEF to 0x0200, then load from 0x0000: rdata=0xBEEF.
REQ-040 Store 0xAAAA to 0x0030; assert rst in the third BUSY cycle; release; load 0x0030: value is not 0xAAAA (pre-loaded 0x5555 expected); stall=0 immediately at reset.
REQ-041 halt=1 in IDLE, then load from 0x0010: state stays HALTED, stall=0, done never pulses, rdata unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Multi-cycle data memory controller for the MEM stage of the pipeline.
//   It accepts one load or store from EX/MEM, stalls the pipeline while the
//   access is in flight, then pulses done for one cycle. The storage is an
//   array of 2^AW 16-bit words, indexed by the halfword address addr[AW:1].
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous active-high reset
//   addr   in  16   byte address (ALUOut_EM)
//   wdata  in  16   store data (R2Data_EM)
//   rd_en  in   1   load request (memReadEnable_EM)
//   wr_en  in   1   store request (memWriteEnable_EM)
//   halt   in   1   halt marker (halt_EM)
//   rdata  out 16   last load result, held until the next load completes
//   done   out  1   one-cycle completion pulse
//   stall  out  1   freezes EX/MEM and upstream stages while high
//   err    out  1   illegal request flag (misaligned or both enables set)
module data_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        halt,
  output logic [15:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   wbuf_q, wbuf_d;
  logic          is_store_q, is_store_d;
  logic [15:0]   rdata_q, rdata_d;

  logic [15:0]   mem [0:(1<<AW)-1];

  logic          req;
  logic          req_valid;
  logic          access_now;
  logic          mem_we;
  logic          unused_addr;

  // Address bits above AW are ignored on purpose, so addresses alias.
  assign unused_addr = ^addr;

  assign req        = rd_en | wr_en;
  assign req_valid  = req && !addr[0] && (rd_en ^ wr_en);
  assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
  // Gating with rst keeps an aborted store from landing in the array.
  assign mem_we     = access_now && is_store_q && !rst;

  assign rdata = rdata_q;

  // Next-state and output decode. In IDLE any request, valid or not, takes
  // priority over halt; an invalid one just raises err and stays put.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wbuf_d     = wbuf_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_valid) begin
            stall      = 1'b1;
            idx_d      = addr[AW:1];
            wbuf_d     = wdata;
            is_store_d = wr_en;
            cnt_d      = 4'(LATENCY - 1);
            state_d    = BUSY;
          end else begin
            err = 1'b1;
          end
        end else if (halt) begin
          state_d = HALTED;
        end
      end

      // cnt counts down from LATENCY-1, so BUSY lasts LATENCY cycles and the
      // array is touched on the edge where cnt has reached zero.
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!is_store_q) begin
            rdata_d = mem[idx_q];
          end
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wbuf_q     <= 16'h0000;
      is_store_q <= 1'b0;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wbuf_q     <= wbuf_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
    end
  end

  // The array itself has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wbuf_q;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Directed and randomized checks of data_mem_ctrl against a word-array
//   reference model with LATENCY=4, AW=8.
module tb_data_mem_ctrl;

  localparam int LATENCY = 4;
  localparam int AW      = 8;
  localparam int DEPTH   = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic        halt;
  logic [15:0] rdata;
  logic        done;
  logic        stall;
  logic        err;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [15:0] model_mem [DEPTH];
  bit          written   [DEPTH];
  logic [15:0] exp_rdata;

  data_mem_ctrl #(
    .LATENCY(LATENCY),
    .AW     (AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .wdata(wdata),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .halt (halt),
    .rdata(rdata),
    .done (done),
    .stall(stall),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word index as the memory sees it: halfword address modulo array depth.
  function automatic int idxOf(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d,
                               input logic rd, input logic wr, input logic h);
    addr  = a;
    wdata = d;
    rd_en = rd;
    wr_en = wr;
    halt  = h;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  // One legal access from IDLE: counts stall cycles up to the done pulse,
  // then compares timing and rdata with the model.
  task automatic doAccess(input string tag, input logic [15:0] a,
                          input logic [15:0] d, input bit is_load, input bit h);
    int stall_cycles;
    bit done_seen;
    stall_cycles = 0;
    done_seen    = 0;
    applyStimulus(a, d, is_load, !is_load, h);
    #1;
    checkOutput({tag, "_err"}, {15'd0, err}, 16'd0);
    if (stall) stall_cycles++;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(posedge clk);
      #2;
      if (done) done_seen = 1;
      else if (stall) stall_cycles++;
    end
    if (is_load) begin
      exp_rdata = model_mem[idxOf(a)];
    end else begin
      model_mem[idxOf(a)] = d;
      written[idxOf(a)]   = 1;
    end
    checkOutput({tag, "_done_seen"}, {15'd0, done_seen}, 16'd1);
    checkOutput({tag, "_stall_cycles"}, 16'(stall_cycles), 16'(LATENCY + 1));
    checkOutput({tag, "_stall_in_done"}, {15'd0, stall}, 16'd0);
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput({tag, "_done_one_cycle"}, {15'd0, done}, 16'd0);
  endtask

  // Illegal request held in IDLE: err with no stall and no completion.
  task automatic badRequest(input string tag, input logic [15:0] a,
                            input logic [15:0] d, input logic rd, input logic wr);
    applyStimulus(a, d, rd, wr, 1'b0);
    #1;
    checkOutput({tag, "_err"}, {15'd0, err}, 16'd1);
    checkOutput({tag, "_stall"}, {15'd0, stall}, 16'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      checkOutput({tag, "_done_stall"}, {14'd0, done, stall}, 16'd0);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_err_clear"}, {15'd0, err}, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 16'hxxxx;
      written[i]   = 0;
    end
    exp_rdata = 16'h0000;

    // Reset state
    rst = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("reset_outputs", {13'd0, done, stall, err}, 16'd0);
    checkOutput("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Store then load to the same address
    doAccess("store_1234", 16'h0010, 16'h1234, 0, 0);
    doAccess("load_1234", 16'h0010, 16'h0000, 1, 0);

    // Misaligned load
    badRequest("misaligned", 16'h0011, 16'h0000, 1'b1, 1'b0);

    // Both enables: array must keep the earlier value
    doAccess("store_7777", 16'h0020, 16'h7777, 0, 0);
    badRequest("both_en", 16'h0020, 16'h1111, 1'b1, 1'b1);
    doAccess("load_7777", 16'h0020, 16'h0000, 1, 0);

    // Aliasing: 0x0200 and 0x0000 share word index 0
    doAccess("store_beef", 16'h0200, 16'hBEEF, 0, 0);
    doAccess("load_alias", 16'h0000, 16'h0000, 1, 0);

    // Request and halt together: request wins, controller stays usable
    doAccess("load_with_halt", 16'h0010, 16'h0000, 1, 1);
    doAccess("store_after_halt", 16'h0012, 16'hC0DE, 0, 0);

    // Reset in the third BUSY cycle aborts the store
    doAccess("store_5555", 16'h0030, 16'h5555, 0, 0);
    applyStimulus(16'h0030, 16'hAAAA, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("busy3_stall", {15'd0, stall}, 16'd1);
    rst = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("abort_stall", {15'd0, stall}, 16'd0);
    checkOutput("abort_done", {15'd0, done}, 16'd0);
    checkOutput("abort_rdata", rdata, 16'h0000);
    exp_rdata = 16'h0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    doAccess("load_after_abort", 16'h0030, 16'h0000, 1, 0);

    // Randomized legal and illegal traffic over a small aliased window
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      bit          ld;
      a  = 16'($urandom_range(0, 7) * 2 + $urandom_range(0, 1) * 512
               + $urandom_range(0, 1) * 16'h4000);
      d  = 16'($urandom);
      ld = ($urandom_range(0, 1) == 1) && written[idxOf(a)];
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) badRequest("rand_odd", a | 16'h0001, d, 1'b1, 1'b0);
        else badRequest("rand_both", a, d, 1'b1, 1'b1);
      end else begin
        doAccess(ld ? "rand_load" : "rand_store", a, d, ld, 0);
      end
    end

    // Halt in IDLE, then requests are ignored
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("halted_stall", {15'd0, stall}, 16'd0);
    checkOutput("halted_err", {15'd0, err}, 16'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #2;
      checkOutput("halted_done_stall", {14'd0, done, stall}, 16'd0);
      checkOutput("halted_rdata", rdata, exp_rdata);
    end
    applyStimulus(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("halted_bad_err", {15'd0, err}, 16'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
